// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: shared state type and constants for the interrupt controller
package irq_controller_pkg;
  localparam int NUM_IRQ_LINES = 8;
  localparam int IRQ_VECTOR_STRIDE = 4;
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} irq_state_t;
endpackage

// File: rtl/irq_edge_detect.sv
// irq_edge_detect: per-line rising-edge pulse, optional two-flop synchronizer (IRQ_SYNC_EN)
module irq_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic rise
);
  logic sampled;
  logic prev;
`ifdef IRQ_SYNC_EN
  logic [1:0] sync;
  // two-flop synchronizer for asynchronous peripheral lines
  always_ff @(posedge clock or negedge reset)
    if (!reset) sync <= '0;
    else sync <= {sync[0], line};
  assign sampled = sync[1];
`else
  assign sampled = line;
`endif
  // previous sample; cleared on reset so a line already high counts as an edge
  always_ff @(posedge clock or negedge reset)
    if (!reset) prev <= 1'b0;
    else prev <= sampled;
  assign rise = sampled & ~prev;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, maskable, fixed-priority interrupt controller (IRQ_SYNC_EN adds input synchronizers)
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          NUM_LINES   = NUM_IRQ_LINES,
  parameter logic [15:0] VECTOR_BASE = 16'h0010
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] irq_lines,
  input  logic                 mask_write,
  input  logic [NUM_LINES-1:0] mask_data,
  input  logic                 reset_irq,
  output logic                 irq,
  output logic [15:0]          irq_vector,
  output logic [2:0]           irq_id,
  output logic [NUM_LINES-1:0] pending
);
  logic [NUM_LINES-1:0] rise, mask, req, clr;
  logic [2:0] grant;
  irq_state_t state, state_next;
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_edge
    irq_edge_detect u_edge (
      .clock(clock),
      .reset(reset),
      .line (irq_lines[g]),
      .rise (rise[g])
    );
  end
  assign req = pending & mask;
  // lowest enabled pending line wins; ack clears only the granted line
  always_comb begin
    grant = '0;
    clr = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (req[i]) grant = 3'(i);
      clr[i] = state == ASSERT && reset_irq && irq_id == 3'(i);
    end
  end
  // next state: holdoff always lasts exactly one cycle
  always_comb begin
    state_next = state;
    state_next = state == IDLE   ? (|req ? ASSERT : IDLE) :
                 state == ASSERT ? (reset_irq ? HOLDOFF : ASSERT) : IDLE;
  end
  // state, pending (set wins over ack), mask and latched grant
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      pending <= '0;
      mask <= '0;
      irq_id <= '0;
    end else begin
      state <= state_next;
      pending <= (pending & ~clr) | rise;
      if (mask_write) mask <= mask_data;
      if (state == IDLE && |req) irq_id <= grant;
    end
  assign irq = state == ASSERT;
  assign irq_vector = VECTOR_BASE + 16'(irq_id) * 16'(IRQ_VECTOR_STRIDE);
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: table-driven, hand-sequenced and randomized checks against a behavioural model
module tb_irq_controller;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam logic [15:0] VB = 16'h0010;

  logic clock, reset, mask_write, reset_irq, irq;
  logic [7:0] irq_lines, mask_data, pending;
  logic [15:0] irq_vector;
  logic [2:0] irq_id;
  int tests = 0, fails = 0;

  irq_controller #(.NUM_LINES(8), .VECTOR_BASE(VB)) dut (
    .clock(clock), .reset(reset), .irq_lines(irq_lines), .mask_write(mask_write),
    .mask_data(mask_data), .reset_irq(reset_irq), .irq(irq), .irq_vector(irq_vector),
    .irq_id(irq_id), .pending(pending)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // behavioural model: 0=idle, 1=requesting, 2=holdoff
  logic [7:0] m_pend, m_mask, m_prev_seen;
  logic [7:0] m_past[2];
  int m_state;
  logic [2:0] m_id;

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_prev_seen = 0; m_past[0] = 0; m_past[1] = 0;
    m_state = 0; m_id = 0;
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] r);
    for (int i = 0; i < 8; i++) if (r[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic model_edge();
    logic [7:0] seen, req, clr;
    if (!reset) begin
      model_reset();
      return;
    end
    seen = (LAT == 1) ? irq_lines : m_past[1];
    req = m_pend & m_mask;
    clr = (m_state == 1 && reset_irq) ? (8'd1 << m_id) : 8'd0;
    m_pend = (m_pend & ~clr) | (seen & ~m_prev_seen);
    m_prev_seen = seen;
    m_past[1] = m_past[0];
    m_past[0] = irq_lines;
    if (mask_write) m_mask = mask_data;
    if (m_state == 0) begin
      if (req != 0) begin
        m_state = 1;
        m_id = lowest(req);
      end
    end else if (m_state == 1) begin
      if (reset_irq) m_state = 2;
    end else m_state = 0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_irq", 16'(irq), 16'(m_state == 1));
    chk("model_id", 16'(irq_id), 16'(m_id));
    chk("model_vector", irq_vector, 16'(VB + 16'(m_id) * 16'd4));
    chk("model_pending", 16'(pending), 16'(m_pend));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_model();
  endtask

  typedef struct {
    logic [7:0] lines;
    logic mw;
    logic [7:0] md;
    logic ack;
    logic long_wait;
    logic e_irq;
    logic [2:0] e_id;
    logic [15:0] e_vec;
    logic [7:0] e_pend;
  } vec_t;
  vec_t tbl[$];

  initial begin
    int got;
    irq_lines = 0; mask_write = 0; mask_data = 0; reset_irq = 0; reset = 0;
    model_reset();
    step();
    step();
    chk("reset_irq", 16'(irq), 16'd0);
    chk("reset_vector", irq_vector, 16'h0010);
    chk("reset_pending", 16'(pending), 16'd0);
    reset = 1;

    // mask 04, line 2 request
    tbl.push_back('{8'h00, 1, 8'h04, 0, 0, 0, 3'd0, 16'h0010, 8'h00});
    tbl.push_back('{8'h04, 0, 8'h00, 0, 1, 0, 3'd0, 16'h0010, 8'h04});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 3'd2, 16'h0018, 8'h04});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 3'd2, 16'h0018, 8'h04});
    tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 3'd2, 16'h0018, 8'h00});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 3'd2, 16'h0018, 8'h00});
    // masked line 3 latches, request appears once mask enables it
    tbl.push_back('{8'h00, 1, 8'h00, 0, 0, 0, 3'd2, 16'h0018, 8'h00});
    tbl.push_back('{8'h08, 0, 8'h00, 0, 1, 0, 3'd2, 16'h0018, 8'h08});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 3'd2, 16'h0018, 8'h08});
    tbl.push_back('{8'h00, 1, 8'h08, 0, 0, 0, 3'd2, 16'h0018, 8'h08});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 3'd3, 16'h001C, 8'h08});
    tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 3'd3, 16'h001C, 8'h00});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 3'd3, 16'h001C, 8'h00});
    // lines 5 and 1 together: 1 first, holdoff, then 5
    tbl.push_back('{8'h00, 1, 8'hFF, 0, 0, 0, 3'd3, 16'h001C, 8'h00});
    tbl.push_back('{8'h22, 0, 8'h00, 0, 1, 0, 3'd3, 16'h001C, 8'h22});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 3'd1, 16'h0014, 8'h22});
    tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 3'd1, 16'h0014, 8'h20});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 3'd1, 16'h0014, 8'h20});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 1, 3'd5, 16'h0024, 8'h20});
    tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 3'd5, 16'h0024, 8'h00});
    tbl.push_back('{8'h00, 0, 8'h00, 0, 0, 0, 3'd5, 16'h0024, 8'h00});
    tbl.push_back('{8'h00, 0, 8'h00, 1, 0, 0, 3'd5, 16'h0024, 8'h00});

    foreach (tbl[k]) begin
      irq_lines = tbl[k].lines; mask_write = tbl[k].mw; mask_data = tbl[k].md;
      reset_irq = tbl[k].ack;
      repeat (tbl[k].long_wait ? LAT : 1) step();
      chk($sformatf("tbl%0d_irq", k), 16'(irq), 16'(tbl[k].e_irq));
      chk($sformatf("tbl%0d_id", k), 16'(irq_id), 16'(tbl[k].e_id));
      chk($sformatf("tbl%0d_vec", k), irq_vector, tbl[k].e_vec);
      chk($sformatf("tbl%0d_pend", k), 16'(pending), 16'(tbl[k].e_pend));
    end
    mask_write = 0; reset_irq = 0;

    // new edge on line 0 coincident with its acknowledge: set wins
    irq_lines = 8'h01;
    repeat (LAT) step();
    irq_lines = 8'h00;
    step();
    chk("coinc_assert", 16'(irq), 16'd1);
    chk("coinc_id", 16'(irq_id), 16'd0);
    irq_lines = 8'h01;
    repeat (LAT - 1) step();
    reset_irq = 1;
    step();
    reset_irq = 0; irq_lines = 8'h00;
    chk("coinc_pend0", 16'(pending[0]), 16'd1);
    chk("coinc_holdoff", 16'(irq), 16'd0);
    step();
    chk("coinc_idle", 16'(irq), 16'd0);
    step();
    chk("coinc_reassert", 16'(irq), 16'd1);
    reset_irq = 1;
    step();
    reset_irq = 0;
    step();

    // level held across ack gives one request only
    irq_lines = 8'h10;
    repeat (LAT) step();
    step();
    chk("hold_id", 16'(irq_id), 16'd4);
    reset_irq = 1;
    step();
    reset_irq = 0;
    repeat (6) step();
    chk("hold_no_rereq", 16'(irq), 16'd0);
    chk("hold_pend", 16'(pending), 16'd0);

    // async reset mid-request
    irq_lines = 8'h50;
    repeat (LAT) step();
    step();
    chk("pre_reset_irq", 16'(irq), 16'd1);
    chk("pre_reset_id", 16'(irq_id), 16'd6);
    #2 reset = 0;
    #1;
    model_reset();
    chk("async_irq", 16'(irq), 16'd0);
    chk("async_pend", 16'(pending), 16'd0);
    chk("async_id", 16'(irq_id), 16'd0);
    chk("async_vec", irq_vector, 16'h0010);
    step();
    reset = 1;
    mask_write = 1; mask_data = 8'hFF;
    step();
    mask_write = 0;
    repeat (LAT - 1) step();
    chk("release_high_edge", 16'(pending), 16'h0050);

    // set latency measurement on line 7
    irq_lines = 8'h50;
    step();
    irq_lines = 8'hD0;
    got = 0;
    for (int n = 1; n <= 10; n++) begin
      step();
      if (pending[7]) begin
        got = n;
        break;
      end
    end
    chk("set_latency", 16'(got), 16'(LAT));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      irq_lines = irq_lines ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      mask_write = $urandom_range(0, 9) == 0;
      mask_data = 8'($urandom);
      reset_irq = $urandom_range(0, 2) == 0;
      step();
    end
    mask_write = 0; reset_irq = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
